// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package display_pkg;

   localparam int         DEF_NUM_DIGITS = 6;
   localparam logic [3:0] SEG_OFF_CODE   = 4'hF;

   typedef enum logic {
      SCAN_BLANK = 1'b0,
      SCAN_SHOW  = 1'b1
   } scan_state_t;

   // Counter width for a modulus, never narrower than one bit.
   function automatic int cnt_w(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/clk_tick_div.sv
// Free-running modulo-MOD counter with a one-cycle wrap flag on its last count.
module clk_tick_div
   import display_pkg::*;
#(
   parameter  int MOD = 2,
   localparam int CW  = cnt_w(MOD)
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] cnt,
   output logic          wrap
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      wrap  = (cnt_q == CW'(MOD - 1));
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan: per-slot blanking, blink, leading-zero
// suppression and whole-frame snapshots of the digit inputs.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 16,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lz_en,
   output logic [3:0]              hex_digit,
   output logic                    blink,
   output logic [NUM_DIGITS-1:0]   digit_sel_n,
   output logic                    frame_start
);

   localparam int SW = cnt_w(SCAN_DIV);
   localparam int IW = cnt_w(NUM_DIGITS);

   logic [SW-1:0] slot_cnt;
   logic          slot_wrap;
   logic          blink_wrap;

   clk_tick_div #(.MOD(SCAN_DIV)) u_slot_div (
      .clk  (clk),
      .rst  (rst),
      .cnt  (slot_cnt),
      .wrap (slot_wrap)
   );

   clk_tick_div #(.MOD(BLINK_DIV)) u_blink_div (
      .clk  (clk),
      .rst  (rst),
      .cnt  (),
      .wrap (blink_wrap)
   );

   scan_state_t               state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic                      phase_q, phase_d;
   logic [4*NUM_DIGITS-1:0]   frame_q, frame_d;
   logic [NUM_DIGITS-1:0]     frame_mask_q, frame_mask_d;
   logic [3:0]                hex_digit_q, hex_digit_d;
   logic                      blink_q, blink_d;
   logic [NUM_DIGITS-1:0]     digit_sel_n_q, digit_sel_n_d;
   logic                      frame_start_q, frame_start_d;

   logic       slot_start;
   logic       snap;
   logic [3:0] cur_val;
   logic       blank_cond;

   // slot_cnt == 0 means the coming edge opens a new slot; all per-slot
   // outputs are loaded on that edge, so they use the freshly snapped frame.
   always_comb begin
      slot_start   = (slot_cnt == '0);
      snap         = slot_start && (idx_q == '0);
      frame_d      = snap ? digits_in  : frame_q;
      frame_mask_d = snap ? blink_mask : frame_mask_q;
      cur_val      = frame_d[{idx_q, 2'b00} +: 4];
      blank_cond   = (frame_mask_d[idx_q] & phase_q)
                   | (lz_en & (idx_q == IW'(NUM_DIGITS - 1)) & (cur_val == 4'd0));

      phase_d = phase_q ^ blink_wrap;

      idx_d = idx_q;
      if (slot_wrap)
         idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

      state_d = state_q;
      case (state_q)
         SCAN_BLANK: if (slot_cnt == SW'(BLANK_CYC - 1)) state_d = SCAN_SHOW;
         SCAN_SHOW:  if (slot_wrap)                      state_d = SCAN_BLANK;
         default:                                        state_d = SCAN_BLANK;
      endcase

      hex_digit_d   = slot_start ? cur_val    : hex_digit_q;
      blink_d       = slot_start ? blank_cond : blink_q;
      frame_start_d = snap;

      // state_q leads the pins by one edge, which puts the enable exactly
      // BLANK_CYC edges after the slot start and drops it on the next start.
      digit_sel_n_d = '1;
      if (state_q == SCAN_SHOW && en)
         digit_sel_n_d[idx_q] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= SCAN_BLANK;
         idx_q         <= '0;
         phase_q       <= 1'b0;
         frame_q       <= '0;
         frame_mask_q  <= '0;
         hex_digit_q   <= SEG_OFF_CODE;
         blink_q       <= 1'b1;
         digit_sel_n_q <= '1;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         phase_q       <= phase_d;
         frame_q       <= frame_d;
         frame_mask_q  <= frame_mask_d;
         hex_digit_q   <= hex_digit_d;
         blink_q       <= blink_d;
         digit_sel_n_q <= digit_sel_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hex_digit   = hex_digit_q;
   assign blink       = blink_q;
   assign digit_sel_n = digit_sel_n_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with an 8-cycle slot and 64-cycle blink.
module tb_display_scan_ctrl;

   localparam int ND = 6;
   localparam int SD = 8;
   localparam int BC = 2;
   localparam int BD = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic [23:0]   digits_in = '0;
   logic [ND-1:0] blink_mask = '0;
   logic          lz_en = 1'b0;
   logic [3:0]    hex_digit;
   logic          blink;
   logic [ND-1:0] digit_sel_n;
   logic          frame_start;

   int errors = 0;
   int checks = 0;

   display_scan_ctrl #(
      .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .digits_in   (digits_in),
      .blink_mask  (blink_mask),
      .lz_en       (lz_en),
      .hex_digit   (hex_digit),
      .blink       (blink),
      .digit_sel_n (digit_sel_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Edge e counts active edges after reset release, starting at 1.
   function automatic int pos_of(int e);
      return (e - 1) % SD;
   endfunction

   function automatic int idx_of(int e);
      return ((e - 1) / SD) % ND;
   endfunction

   function automatic logic [ND-1:0] exp_sel(int e, logic en_v);
      logic [ND-1:0] s;
      s = '1;
      if (pos_of(e) >= BC && en_v) s[idx_of(e)] = 1'b0;
      return s;
   endfunction

   function automatic logic phase_at_slot(int e);
      int s;
      s = e - pos_of(e);
      return (((s - 1) / BD) % 2) == 1;
   endfunction

   function automatic logic [3:0] nib(logic [23:0] v, int i);
      return 4'((v >> (4 * i)) & 24'hF);
   endfunction

   task automatic do_reset(input logic [23:0] d, input logic [ND-1:0] m, input logic lz);
      rst = 1'b1;
      en = 1'b1;
      digits_in = d;
      blink_mask = m;
      lz_en = lz;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (digit_sel_n !== 6'h3F) begin errors++; $display("FAIL reset_sel got=%b exp=%b", digit_sel_n, 6'h3F); end
      checks++; if (hex_digit !== 4'hF) begin errors++; $display("FAIL reset_hex got=%h exp=f", hex_digit); end
      checks++; if (blink !== 1'b1) begin errors++; $display("FAIL reset_blink got=%b exp=1", blink); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
   endtask

   task automatic test_scan();
      logic [3:0] eh;
      do_reset(24'h123456, '0, 1'b0);
      for (int e = 1; e <= 56; e++) begin
         @(posedge clk); @(negedge clk);
         eh = nib(24'h123456, idx_of(e));
         checks++; if (digit_sel_n !== exp_sel(e, 1'b1)) begin errors++; $display("FAIL scan_sel e=%0d got=%b exp=%b", e, digit_sel_n, exp_sel(e, 1'b1)); end
         checks++; if (hex_digit !== eh) begin errors++; $display("FAIL scan_hex e=%0d got=%h exp=%h", e, hex_digit, eh); end
         checks++; if (frame_start !== (pos_of(e) == 0 && idx_of(e) == 0)) begin errors++; $display("FAIL scan_fs e=%0d got=%b", e, frame_start); end
         checks++; if (blink !== 1'b0) begin errors++; $display("FAIL scan_blink e=%0d got=%b exp=0", e, blink); end
      end
   endtask

   task automatic test_snapshot();
      logic [23:0] frame_m;
      logic [3:0]  eh;
      frame_m = '0;
      do_reset(24'h123456, '0, 1'b0);
      for (int e = 1; e <= 96; e++) begin
         if (pos_of(e) == 0 && idx_of(e) == 0) frame_m = digits_in;
         @(posedge clk); @(negedge clk);
         eh = nib(frame_m, idx_of(e));
         checks++; if (hex_digit !== eh) begin errors++; $display("FAIL snap_hex e=%0d got=%h exp=%h", e, hex_digit, eh); end
         if (e == 27) digits_in = 24'h999999;
      end
   endtask

   task automatic test_blink();
      logic eb;
      do_reset(24'h123456, 6'b000011, 1'b0);
      for (int e = 1; e <= 200; e++) begin
         @(posedge clk); @(negedge clk);
         eb = (idx_of(e) < 2) && phase_at_slot(e);
         checks++; if (blink !== eb) begin errors++; $display("FAIL blink e=%0d got=%b exp=%b", e, blink, eb); end
      end
   endtask

   task automatic test_lz();
      do_reset(24'h012345, '0, 1'b1);
      for (int e = 1; e <= 48; e++) begin
         @(posedge clk); @(negedge clk);
         checks++; if (blink !== (idx_of(e) == 5)) begin errors++; $display("FAIL lz_on_blink e=%0d got=%b", e, blink); end
         checks++; if (hex_digit !== nib(24'h012345, idx_of(e))) begin errors++; $display("FAIL lz_on_hex e=%0d got=%h exp=%h", e, hex_digit, nib(24'h012345, idx_of(e))); end
      end
      do_reset(24'h012345, '0, 1'b0);
      for (int e = 1; e <= 48; e++) begin
         @(posedge clk); @(negedge clk);
         if (idx_of(e) == 5) begin
            checks++; if (blink !== 1'b0) begin errors++; $display("FAIL lz_off_blink e=%0d got=%b exp=0", e, blink); end
            checks++; if (hex_digit !== 4'h0) begin errors++; $display("FAIL lz_off_hex e=%0d got=%h exp=0", e, hex_digit); end
         end
      end
   endtask

   task automatic test_enable();
      logic ev;
      do_reset(24'h123456, '0, 1'b0);
      for (int e = 1; e <= 60; e++) begin
         ev = !(e >= 11 && e <= 30);
         en = ev;
         @(posedge clk); @(negedge clk);
         checks++; if (digit_sel_n !== exp_sel(e, ev)) begin errors++; $display("FAIL en_sel e=%0d got=%b exp=%b", e, digit_sel_n, exp_sel(e, ev)); end
         checks++; if (hex_digit !== nib(24'h123456, idx_of(e))) begin errors++; $display("FAIL en_hex e=%0d got=%h exp=%h", e, hex_digit, nib(24'h123456, idx_of(e))); end
         checks++; if (frame_start !== (pos_of(e) == 0 && idx_of(e) == 0)) begin errors++; $display("FAIL en_fs e=%0d got=%b", e, frame_start); end
      end
      en = 1'b1;
   endtask

   task automatic test_async_reset();
      do_reset(24'h123456, '0, 1'b0);
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); @(negedge clk);
      end
      checks++; if (digit_sel_n !== exp_sel(20, 1'b1)) begin errors++; $display("FAIL ar_pre_sel got=%b exp=%b", digit_sel_n, exp_sel(20, 1'b1)); end
      #1 rst = 1'b1;
      #1;
      checks++; if (digit_sel_n !== 6'h3F) begin errors++; $display("FAIL ar_sel got=%b exp=%b", digit_sel_n, 6'h3F); end
      checks++; if (hex_digit !== 4'hF) begin errors++; $display("FAIL ar_hex got=%h exp=f", hex_digit); end
      checks++; if (blink !== 1'b1) begin errors++; $display("FAIL ar_blink got=%b exp=1", blink); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL ar_fs got=%b exp=0", frame_start); end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_snapshot();
      test_blink();
      test_lz();
      test_enable();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
